// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file: destination class
// codes, special-register offsets and the zero data constant.
package reg_file_sb_pkg;

    localparam int REG_OP_W = 3;

    typedef enum logic [REG_OP_W-1:0] {
        REG_OP_NOP = 3'd0,
        REG_OP_REG = 3'd1,
        REG_OP_T   = 3'd2,
        REG_OP_SP  = 3'd3,
        REG_OP_IH  = 3'd4,
        REG_OP_RA  = 3'd5
    } reg_op_e;

    localparam logic [15:0] DATA_ZERO = 16'h0000;

    localparam int SPEC_T  = 0;
    localparam int SPEC_SP = 1;
    localparam int SPEC_IH = 2;
    localparam int SPEC_RA = 3;
    localparam int SPEC_NUM = 4;

endpackage

// File: rtl/reg_sb_counter.sv
// Pending-write counter for one destination: saturating up/down with flush
// clear. The one-flag exists only when REG_FILE_BYPASS_EN is defined.
module reg_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic flush,
    output logic is_zero,
`ifdef REG_FILE_BYPASS_EN
    output logic is_one,
`endif
    output logic is_max
);

    logic [CNT_W-1:0] cnt;

    // A claim and a release on the same cycle cancel; release never underflows.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_zero = (cnt == '0);
`ifdef REG_FILE_BYPASS_EN
    assign is_one  = (cnt == CNT_W'(1));
`endif
    assign is_max  = (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/reg_file_sb.sv
// Register file with N read ports, one write-back port, T/SP/IH/RA and a
// pending-write scoreboard. Same-cycle forwarding under REG_FILE_BYPASS_EN.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int GPR_NUM  = 8,
    parameter int ADDR_W   = 3,
    parameter int RD_PORTS = 2,
    parameter int CNT_W    = 2
) (
    input  logic                         clk_50MHz,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_ready,
    input  logic [REG_OP_W-1:0]          claim_op,
    input  logic [ADDR_W-1:0]            claim_addr,
    output logic                         claim_ok,
    input  logic [REG_OP_W-1:0]          wb_op,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         flush,
    output logic [DATA_W-1:0]            T_data,
    output logic [DATA_W-1:0]            SP_data,
    output logic [DATA_W-1:0]            IH_data,
    output logic [DATA_W-1:0]            RA_data,
    output logic [SPEC_NUM-1:0]          spec_ready
);

    localparam int DEST_NUM = GPR_NUM + SPEC_NUM;
    localparam int DW = $clog2(DEST_NUM);

    logic [DATA_W-1:0] regs [DEST_NUM];
    logic [DEST_NUM-1:0] cnt_zero;
    logic [DEST_NUM-1:0] cnt_max;
`ifdef REG_FILE_BYPASS_EN
    logic [DEST_NUM-1:0] cnt_one;
`endif

    logic          claim_valid;
    logic [DW-1:0] claim_idx;
    logic          wb_valid;
    logic [DW-1:0] wb_idx;
    logic [DATA_W-1:0] spec_data [SPEC_NUM];

    // Maps an op/address pair to a flat destination index; undefined codes and
    // out-of-range GPR addresses come back invalid.
    function automatic logic [DW:0] decode_dest(input logic [REG_OP_W-1:0] op,
                                                input logic [ADDR_W-1:0] addr);
        logic [DW:0] res;
        res = '0;
        case (op)
            REG_OP_REG: if (int'(addr) < GPR_NUM) res = {1'b1, DW'(addr)};
            REG_OP_T:   res = {1'b1, DW'(GPR_NUM + SPEC_T)};
            REG_OP_SP:  res = {1'b1, DW'(GPR_NUM + SPEC_SP)};
            REG_OP_IH:  res = {1'b1, DW'(GPR_NUM + SPEC_IH)};
            REG_OP_RA:  res = {1'b1, DW'(GPR_NUM + SPEC_RA)};
            default:    res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        {claim_valid, claim_idx} = decode_dest(claim_op, claim_addr);
        {wb_valid, wb_idx}       = decode_dest(wb_op, wb_addr);
    end

    assign claim_ok = claim_valid && !cnt_max[claim_idx] && !flush;

    // Data writes still land during a flush; only the scoreboard is discarded.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < DEST_NUM; d++) begin
                regs[d] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_idx] <= wb_data;
        end
    end

    for (genvar d = 0; d < DEST_NUM; d++) begin : g_cnt
        reg_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_50MHz(clk_50MHz),
            .rst      (rst),
            .inc      (claim_ok && (claim_idx == DW'(d))),
            .dec      (wb_valid && (wb_idx == DW'(d))),
            .flush    (flush),
            .is_zero  (cnt_zero[d]),
`ifdef REG_FILE_BYPASS_EN
            .is_one   (cnt_one[d]),
`endif
            .is_max   (cnt_max[d])
        );
    end

    // Forwarding only applies to the last outstanding write (count of one).
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DW-1:0] idx;
        rd_data  = '0;
        rd_ready = '1;
        a = '0;
        idx = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            if (int'(a) < GPR_NUM) begin
                idx = DW'(a);
                rd_data[i*DATA_W +: DATA_W] = regs[idx];
                rd_ready[i] = cnt_zero[idx];
`ifdef REG_FILE_BYPASS_EN
                if (wb_valid && (wb_idx == idx) && cnt_one[idx]) begin
                    rd_data[i*DATA_W +: DATA_W] = wb_data;
                    rd_ready[i] = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        logic [DW-1:0] sidx;
        sidx = '0;
        for (int k = 0; k < SPEC_NUM; k++) begin
            sidx = DW'(GPR_NUM + k);
            spec_data[k]  = regs[sidx];
            spec_ready[k] = cnt_zero[sidx];
`ifdef REG_FILE_BYPASS_EN
            if (wb_valid && (wb_idx == sidx) && cnt_one[sidx]) begin
                spec_data[k]  = wb_data;
                spec_ready[k] = 1'b1;
            end
`endif
        end
    end

    assign T_data  = spec_data[SPEC_T];
    assign SP_data = spec_data[SPEC_SP];
    assign IH_data = spec_data[SPEC_IH];
    assign RA_data = spec_data[SPEC_RA];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a cycle-by-cycle vector table plus
// hand-written reset and special-register sequences.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_50MHz = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [1:0]  rd_ready;
    logic [2:0]  claim_op = 3'd0;
    logic [2:0]  claim_addr = '0;
    logic        claim_ok;
    logic [2:0]  wb_op = 3'd0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [15:0] T_data, SP_data, IH_data, RA_data;
    logic [3:0]  spec_ready;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        logic [2:0]  cop;
        logic [2:0]  caddr;
        logic [2:0]  wop;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        fl;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic        eok;
        logic [15:0] ed0;
        logic        er0;
        logic [15:0] ed1;
        logic        er1;
        logic [3:0]  esr;
    } vec_t;

    vec_t vecs[$];

    reg_file_sb dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .claim_op  (claim_op),
        .claim_addr(claim_addr),
        .claim_ok  (claim_ok),
        .wb_op     (wb_op),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .T_data    (T_data),
        .SP_data   (SP_data),
        .IH_data   (IH_data),
        .RA_data   (RA_data),
        .spec_ready(spec_ready)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [2:0] cop, input logic [2:0] caddr,
                          input logic [2:0] wop, input logic [2:0] waddr,
                          input logic [15:0] wdata, input logic fl,
                          input logic [2:0] ra0, input logic [2:0] ra1,
                          input logic eok, input logic [15:0] ed0, input logic er0,
                          input logic [15:0] ed1, input logic er1, input logic [3:0] esr);
        vec_t v;
        v = '{cop, caddr, wop, waddr, wdata, fl, ra0, ra1, eok, ed0, er0, ed1, er1, esr};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        claim_op   = v.cop;
        claim_addr = v.caddr;
        wb_op      = v.wop;
        wb_addr    = v.waddr;
        wb_data    = v.wdata;
        flush      = v.fl;
        rd_addr    = {v.ra1, v.ra0};
    endtask

    task automatic checkOutput(input int n, input vec_t v);
        checkVal($sformatf("v%0d claim_ok", n), 32'(claim_ok), 32'(v.eok));
        checkVal($sformatf("v%0d rd_data0", n), 32'(rd_data[15:0]), 32'(v.ed0));
        checkVal($sformatf("v%0d rd_ready0", n), 32'(rd_ready[0]), 32'(v.er0));
        checkVal($sformatf("v%0d rd_data1", n), 32'(rd_data[31:16]), 32'(v.ed1));
        checkVal($sformatf("v%0d rd_ready1", n), 32'(rd_ready[1]), 32'(v.er1));
        checkVal($sformatf("v%0d spec_ready", n), 32'(spec_ready), 32'(v.esr));
    endtask

    localparam logic [2:0] NOP = 3'd0, RG = 3'd1, TT = 3'd2, SP = 3'd3, IH = 3'd4;

    initial begin
        // claim/stall/release on r3
        addVec(NOP,0, NOP,0,16'h0,   0, 0,1, 0, 16'h0,1, 16'h0,1, 4'hF);
        addVec(RG,3,  NOP,0,16'h0,   0, 3,0, 1, 16'h0,1, 16'h0,1, 4'hF);
        addVec(NOP,0, NOP,0,16'h0,   0, 3,3, 0, 16'h0,0, 16'h0,0, 4'hF);
        addVec(NOP,0, RG,3,16'h1234, 0, 3,0, 0, BYP ? 16'h1234 : 16'h0, BYP, 16'h0,1, 4'hF);
        addVec(NOP,0, NOP,0,16'h0,   0, 3,0, 0, 16'h1234,1, 16'h0,1, 4'hF);
        // SP saturation and release
        addVec(SP,0,  NOP,0,16'h0,   0, 0,0, 1, 16'h0,1, 16'h0,1, 4'hF);
        addVec(SP,0,  NOP,0,16'h0,   0, 0,0, 1, 16'h0,1, 16'h0,1, 4'hD);
        addVec(SP,0,  NOP,0,16'h0,   0, 0,0, 1, 16'h0,1, 16'h0,1, 4'hD);
        addVec(SP,0,  NOP,0,16'h0,   0, 0,0, 0, 16'h0,1, 16'h0,1, 4'hD);
        addVec(NOP,0, SP,0,16'h0001, 0, 0,0, 0, 16'h0,1, 16'h0,1, 4'hD);
        addVec(NOP,0, SP,0,16'h0002, 0, 0,0, 0, 16'h0,1, 16'h0,1, 4'hD);
        addVec(NOP,0, SP,0,16'h0003, 0, 0,0, 0, 16'h0,1, 16'h0,1, BYP ? 4'hF : 4'hD);
        addVec(NOP,0, SP,0,16'h0004, 0, 0,0, 0, 16'h0,1, 16'h0,1, 4'hF);
        addVec(SP,0,  NOP,0,16'h0,   0, 0,0, 1, 16'h0,1, 16'h0,1, 4'hF);
        addVec(NOP,0, SP,0,16'h0005, 0, 0,0, 0, 16'h0,1, 16'h0,1, BYP ? 4'hF : 4'hD);
        // simultaneous claim and write-back
        addVec(RG,5,  NOP,0,16'h0,   0, 5,0, 1, 16'h0,1, 16'h0,1, 4'hF);
        addVec(RG,5,  RG,5,16'h5555, 0, 5,5, 1, BYP ? 16'h5555 : 16'h0, BYP,
               BYP ? 16'h5555 : 16'h0, BYP, 4'hF);
        addVec(NOP,0, NOP,0,16'h0,   0, 5,5, 0, 16'h5555,0, 16'h5555,0, 4'hF);
        addVec(RG,2,  RG,6,16'h6666, 0, 2,6, 1, 16'h0,1, 16'h0,1, 4'hF);
        addVec(NOP,0, NOP,0,16'h0,   0, 2,6, 0, 16'h0,0, 16'h6666,1, 4'hF);
        // flush with a concurrent write-back and a rejected claim
        addVec(RG,1,  NOP,0,16'h0,   0, 1,4, 1, 16'h0,1, 16'h0,1, 4'hF);
        addVec(RG,4,  NOP,0,16'h0,   0, 1,4, 1, 16'h0,0, 16'h0,1, 4'hF);
        addVec(IH,0,  NOP,0,16'h0,   0, 1,4, 1, 16'h0,0, 16'h0,0, 4'hF);
        addVec(RG,7,  TT,0,16'hBEEF, 1, 1,4, 0, 16'h0,0, 16'h0,0, 4'hB);
        addVec(NOP,0, NOP,0,16'h0,   0, 1,7, 0, 16'h0,1, 16'h0,1, 4'hF);
        addVec(NOP,0, NOP,0,16'h0,   0, 2,5, 0, 16'h0,1, 16'h5555,1, 4'hF);
        // undefined op codes do nothing
        addVec(3'd6,0, 3'd7,0,16'hDEAD, 0, 0,1, 0, 16'h0,1, 16'h0,1, 4'hF);
        addVec(NOP,0, NOP,0,16'h0,   0, 0,1, 0, 16'h0,1, 16'h0,1, 4'hF);

        #25 rst = 1'b1;

        // reset state of every GPR and special register
        for (int i = 0; i < 8; i += 2) begin
            @(negedge clk_50MHz);
            rd_addr = {3'(i + 1), 3'(i)};
            #2;
            checkVal($sformatf("reset r%0d", i), 32'(rd_data[15:0]), 32'h0);
            checkVal($sformatf("reset r%0d", i + 1), 32'(rd_data[31:16]), 32'h0);
            checkVal($sformatf("reset ready r%0d/r%0d", i, i + 1), 32'(rd_ready), 32'h3);
        end
        checkVal("reset specials", {T_data, SP_data} | {IH_data, RA_data}, 32'h0);
        checkVal("reset claim_ok", 32'(claim_ok), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_50MHz);
            applyStimulus(vecs[i]);
            #2;
            checkOutput(i, vecs[i]);
            @(posedge clk_50MHz);
        end

        @(negedge clk_50MHz);
        applyStimulus(vecs[0]);
        #2;
        checkVal("T_data after flush", 32'(T_data), 32'hBEEF);
        checkVal("SP_data after releases", 32'(SP_data), 32'h0005);
        checkVal("IH/RA untouched", {IH_data, RA_data}, 32'h0);

        // async reset mid-operation: r7 holds data with two pending writes
        wb_op = RG; wb_addr = 3'd7; wb_data = 16'hAAAA;
        @(negedge clk_50MHz);
        wb_op = NOP; claim_op = RG; claim_addr = 3'd7;
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        claim_op = NOP; rd_addr = {3'd0, 3'd7};
        #2;
        checkVal("pre-reset r7 data", 32'(rd_data[15:0]), 32'hAAAA);
        checkVal("pre-reset r7 ready", 32'(rd_ready[0]), 32'h0);
        checkVal("pre-reset T_data", 32'(T_data), 32'hBEEF);
        #3 rst = 1'b0;
        #1;
        checkVal("async reset r7 data", 32'(rd_data[15:0]), 32'h0);
        checkVal("async reset r7 ready", 32'(rd_ready[0]), 32'h1);
        checkVal("async reset T_data", 32'(T_data), 32'h0);
        checkVal("async reset SP_data", 32'(SP_data), 32'h0);
        checkVal("async reset spec_ready", 32'(spec_ready), 32'hF);
        #2 rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with N read ports, one write-back port, the four special registers (T, SP, IH, RA) and a per-destination pending-write scoreboard. The scoreboard tells the decode stage whether each operand is safe to read. It sits between decode (reads and claims) and write-back (writes and releases). It replaces the fixed two-port register file in the next-generation pipeline.

## Interface
- DATA_W, 16, register width in bits.
- GPR_NUM, 8, number of general-purpose registers.
- ADDR_W, 3, GPR address width; must satisfy 2^ADDR_W ≥ GPR_NUM.
- RD_PORTS, 2, number of GPR read ports.
- CNT_W, 2, scoreboard counter width; maximum pending writes per destination is 2^CNT_W−1.

Ports:
- clk_50MHz  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd_data  out  RD_PORTS*DATA_W  packed read data.
- rd_ready  out  RD_PORTS  operand i has no outstanding write, or is bypassed this cycle.
- claim_op  in  REG_OP width  destination class claimed by decode; REG_OP_NOP means no claim.
- claim_addr  in  ADDR_W  GPR index; used only when claim_op = REG_OP_REG.
- claim_ok  out  1  claim accepted this cycle.
- wb_op  in  REG_OP width  write-back destination class; REG_OP_NOP means no write.
- wb_addr  in  ADDR_W  write-back GPR index.
- wb_data  in  DATA_W  write-back data.
- flush  in  1  discards all pending claims.
- T_data, SP_data, IH_data, RA_data  out  DATA_W  special-register contents.
- spec_ready  out  4  per-register ready flags for {RA, IH, SP, T}.

## Operation
- Destination index d: 0..GPR_NUM−1 are the GPRs; GPR_NUM+0..3 are T, SP, IH and RA.
- Each destination has a CNT_W-bit pending counter cnt[d].
- **Reset:** every register and every cnt is 0. All *_data outputs are 0. rd_ready and spec_ready are all 1. claim_ok is 0.
- **Write:** when wb_op ≠ NOP, register[d] ← wb_data at the clock edge.
  - wb_op outside the defined REG_OP set is a no-op.
  - wb_addr ≥ GPR_NUM with REG_OP_REG is a no-op.
- **Claim:** claim_ok = (claim_op ≠ NOP) and cnt[d] < max and not flush and address in range. This is combinational.
- **Counter update:**
  - Accepted claim only: cnt[d] increments.
  - Write-back only: cnt[d] decrements, saturating at 0 (no underflow).
  - Claim and write-back to the same d in the same cycle: cnt unchanged.
  - Claim to d1 and write-back to a different d2: both updates apply.
- **Flush:** every cnt clears to 0 at the next edge. A write-back in the same cycle still updates data. No claim is accepted in a flush cycle.
- **Read:** rd_data[i] = GPR[rd_addr[i]] (combinational). An out-of-range address reads 0 with ready = 1.
- rd_ready[i] = (cnt[rd_addr[i]] == 0), extended by bypass (see Configuration).
- spec_ready[k] follows the same rule as rd_ready, applied to T, SP, IH and RA.
- Reset mid-operation clears all data and all counters immediately; nothing is retained.

## Timing
- Write to read, no bypass: data is visible on rd_data in the cycle after the write edge.
- Claim latency: cnt changes at the edge where claim_ok = 1. rd_ready drops in the following cycle.
- Release latency: cnt decrements at the write-back edge. rd_ready rises in the next cycle, or the same cycle with bypass.
- All outputs are combinational from state plus the current inputs. No output is registered beyond the register and counter state.

## Configuration
- **REG_FILE_BYPASS_EN defined:** when wb_op targets the same destination as a read port and cnt == 1, that port presents wb_data and ready = 1 in the same cycle. The special-register outputs are bypassed the same way. With cnt > 1, ready stays 0, because an older write is still pending.
- **REG_FILE_BYPASS_EN undefined:** no forwarding. Reads return stored values only, and ready follows cnt only.

## Structure
- **Shared package (define file):**
  - REG_OP codes: REG_OP_NOP, REG_OP_REG, REG_OP_T, REG_OP_SP, REG_OP_IH, REG_OP_RA, and the REG_OP bus width.
  - DATA_ZERO.
  - Special-register index offsets (T = 0, SP = 1, IH = 2, RA = 3).
- **Sub-module:** reg_sb_counter, one instance per destination. It implements the saturating up/down counter with flush clear and produces the zero/one flags used for ready and bypass.

## Test plan
- **Reset then read:** rst low, then high; read all GPRs → rd_data = 0x0000 and rd_ready = 1 on every port; T/SP/IH/RA = 0.
- **Claim, stall, release:**
  - claim REG r3 → claim_ok = 1; next cycle rd_addr = 3 gives rd_ready = 0.
  - wb REG r3 = 0x1234 → with bypass, same cycle ready = 1 and data = 0x1234; without bypass, next cycle data = 0x1234 and ready = 1.
- **Saturation:** claim SP three times → cnt = 3; a fourth claim → claim_ok = 0.
  - Three SP write-backs → spec_ready[1] returns to 1.
  - A fourth write-back leaves cnt at 0.
- **Simultaneous events:**
  - claim r5 plus wb r5 with cnt = 1 → cnt stays 1 and ready stays 0.
  - claim r2 plus wb r6 → cnt[2] = 1 and cnt[6] = 0.
- **Flush:** claim r1, r4 and IH, then assert flush with wb T = 0xBEEF → next cycle all ready flags = 1, T_data = 0xBEEF, claim_ok = 0 during flush.
- **Async reset mid-operation:** r7 = 0xAAAA with cnt = 2; drop rst between clock edges → outputs go to 0 and ready goes to 1 immediately, without waiting for a clock edge.
